// File: rtl/pe_array_pkg.sv
// Shared constants, row-state encoding and config clamping for the PE array output path.
// Combinational helpers only; no latency and no flow control of its own.
package pe_array_pkg;

    localparam int          DATA_WIDTH    = 16;
    localparam int          FP16_SIGN_BIT = 15;
    localparam logic [15:0] FP16_ZERO     = 16'h0000;
    localparam int          MAX_FILTER    = 5;
    localparam int          MAX_STRIDE    = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } row_state_e;

    typedef struct packed {
        logic [2:0] fs;
        logic [2:0] st;
        logic       relu;
    } row_cfg_t;

    function automatic logic [2:0] clamp_fs(input logic [2:0] fs);
        if (fs == 3'd0) begin
            return 3'd1;
        end
        if (fs > 3'(MAX_FILTER)) begin
            return 3'(MAX_FILTER);
        end
        return fs;
    endfunction

    function automatic logic [2:0] clamp_st(input logic [2:0] st);
        if (st == 3'd0) begin
            return 3'd1;
        end
        if (st > 3'(MAX_STRIDE)) begin
            return 3'(MAX_STRIDE);
        end
        return st;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: a push is visible at head_dat_o one cycle later.
// Push while full is accepted only together with a pop; otherwise it is ignored here and the parent flags it.
module sync_fifo_fwft #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push_i,
    input  logic [DATA_WIDTH-1:0]         push_dat_i,
    input  logic                          pop_i,
    output logic [DATA_WIDTH-1:0]         head_dat_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_fifo_fwft: FIFO_DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q,  count_d;
    logic                  do_push;
    logic                  do_pop;

    assign full_o     = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    // Gate the head so an empty FIFO presents zero rather than a stale entry.
    assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/pe_array_out_collector.sv
// Drops per-row warm-up samples, decimates by stride, optional ReLU, buffers kept results in a FWFT FIFO.
// Latency 1 cycle sample-to-out_valid; on a full FIFO without a pop the sample is dropped and overflow sticks.
module pe_array_out_collector #(
    parameter int DATA_WIDTH = pe_array_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2:0]                    filter_size,
    input  logic [2:0]                    stride,
    input  logic                          relu_en,
    input  logic                          row_start,
    input  logic                          pe_out_valid,
    input  logic [DATA_WIDTH-1:0]         PE_Array_out,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [CNT_WIDTH-1:0]          row_out_count,
    output logic                          overflow
);

    import pe_array_pkg::*;

    row_cfg_t              cfg_q, cfg_d, cfg_eff;
    row_state_e            state_q, state_d, cur_state;
    logic [2:0]            skip_q, skip_d, cur_skip;
    logic [2:0]            phase_q, phase_d, cur_phase;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cur_cnt;
    logic                  ovf_q, ovf_d;
    logic                  keep;
    logic [DATA_WIDTH-1:0] push_dat;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;

    // A row_start cycle first rebuilds the row state from the port config,
    // then the same cycle's sample is evaluated against that fresh state.
    always_comb begin
        cfg_d     = cfg_q;
        cfg_eff   = cfg_q;
        cur_state = state_q;
        cur_skip  = skip_q;
        cur_phase = phase_q;
        cur_cnt   = cnt_q;
        if (row_start) begin
            cfg_d.fs   = clamp_fs(filter_size);
            cfg_d.st   = clamp_st(stride);
            cfg_d.relu = relu_en;
            cfg_eff    = cfg_d;
            cur_cnt    = '0;
            cur_phase  = '0;
            if (cfg_d.fs == 3'd1) begin
                cur_state = RUN;
                cur_skip  = '0;
            end else begin
                cur_state = WARMUP;
                cur_skip  = cfg_d.fs - 3'd1;
            end
        end

        state_d = cur_state;
        skip_d  = cur_skip;
        phase_d = cur_phase;
        keep    = 1'b0;
        if (pe_out_valid) begin
            case (cur_state)
                WARMUP: begin
                    skip_d = cur_skip - 3'd1;
                    if (cur_skip == 3'd1) begin
                        state_d = RUN;
                        phase_d = '0;
                    end
                end
                RUN: begin
                    keep    = (cur_phase == 3'd0);
                    phase_d = (cur_phase == cfg_eff.st - 3'd1) ? 3'd0 : cur_phase + 3'd1;
                end
                default: begin
                end
            endcase
        end

        cnt_d = cur_cnt;
        if (keep && (cur_cnt != '1)) begin
            cnt_d = cur_cnt + 1'b1;
        end
    end

    // Any sign-set pattern (including -0 and negative NaN) clamps to +0.
    assign push_dat = (cfg_eff.relu && PE_Array_out[DATA_WIDTH-1]) ? DATA_WIDTH'(FP16_ZERO)
                                                                   : PE_Array_out;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign ovf_d     = ovf_q | (keep & fifo_full & ~pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_q   <= '{fs: 3'd1, st: 3'd1, relu: 1'b0};
            state_q <= IDLE;
            skip_q  <= '0;
            phase_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cfg_q   <= cfg_d;
            state_q <= state_d;
            skip_q  <= skip_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    sync_fifo_fwft #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (keep),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_dat_o (out_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    assign row_out_count = cnt_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_pe_array_out_collector.sv
// Bench for pe_array_out_collector: table-driven rows, random traffic against a queue model, hand-written corner cases.
module tb_pe_array_out_collector;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  filter_size;
    logic [2:0]  stride;
    logic        relu_en;
    logic        row_start;
    logic        pe_out_valid;
    logic [15:0] PE_Array_out;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  fifo_count;
    logic [7:0]  row_out_count;
    logic        overflow;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: row index arithmetic plus a bounded queue.
    bit          m_act;
    int          m_fs, m_st, m_idx, m_cnt;
    bit          m_relu, m_ovf;
    logic [15:0] mq[$];
    logic [15:0] got[$];

    typedef struct {
        logic [2:0]  fs;
        logic [2:0]  st;
        bit          relu;
        int          kind;
        int          n;
        int          exp_cnt;
        logic [15:0] exp_first;
    } vec_t;

    vec_t tbl[7];

    pe_array_out_collector dut (
        .clk           (clk),
        .reset         (reset),
        .filter_size   (filter_size),
        .stride        (stride),
        .relu_en       (relu_en),
        .row_start     (row_start),
        .pe_out_valid  (pe_out_valid),
        .PE_Array_out  (PE_Array_out),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .fifo_count    (fifo_count),
        .row_out_count (row_out_count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [15:0] sample_val(input int kind, input int idx);
        logic [15:0] pat[4];
        pat = '{16'hC000, 16'h4000, 16'h8000, 16'h3C00};
        case (kind)
            0:       return 16'hC000 + 16'(idx) * 16'h0400;
            2:       return pat[idx % 4];
            default: return 16'(idx);
        endcase
    endfunction

    task automatic model_clear();
        m_act = 1'b0;
        m_idx = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
        mq.delete();
    endtask

    task automatic model_update();
        bit          pop, keep, full;
        logic [15:0] v, dropped;
        pop  = (mq.size() > 0) && out_ready;
        full = (mq.size() == DEPTH);
        keep = 1'b0;
        if (row_start) begin
            m_act  = 1'b1;
            m_fs   = (filter_size == 0) ? 1 : ((filter_size > 5) ? 5 : int'(filter_size));
            m_st   = (stride == 0) ? 1 : int'(stride);
            m_relu = relu_en;
            m_idx  = 0;
            m_cnt  = 0;
        end
        if (pe_out_valid && m_act) begin
            keep = (m_idx >= m_fs - 1) && (((m_idx - (m_fs - 1)) % m_st) == 0);
            m_idx++;
        end
        if (pop) begin
            dropped = mq.pop_front();
        end
        if (keep) begin
            v = (m_relu && PE_Array_out[15]) ? 16'h0000 : PE_Array_out;
            if (!full || pop) begin
                mq.push_back(v);
            end else begin
                m_ovf = 1'b1;
            end
            if (m_cnt < 255) begin
                m_cnt++;
            end
        end
    endtask

    task automatic compare_all();
        check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("out_data", 32'(out_data), 32'(mq[0]));
        end
        check("fifo_count", 32'(fifo_count), 32'(mq.size()));
        check("row_out_count", 32'(row_out_count), 32'(m_cnt));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step();
        bit          pre_pop;
        logic [15:0] pre_dat;
        pre_pop = out_valid && out_ready;
        pre_dat = out_data;
        @(posedge clk);
        model_update();
        if (pre_pop) begin
            got.push_back(pre_dat);
        end
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        row_start    = 1'b0;
        pe_out_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        tbl[0] = '{fs: 3'd5, st: 3'd1, relu: 1'b0, kind: 0, n: 14, exp_cnt: 10, exp_first: 16'hD000};
        tbl[1] = '{fs: 3'd3, st: 3'd2, relu: 1'b0, kind: 1, n: 12, exp_cnt: 5,  exp_first: 16'h0002};
        tbl[2] = '{fs: 3'd3, st: 3'd0, relu: 1'b0, kind: 1, n: 12, exp_cnt: 10, exp_first: 16'h0002};
        tbl[3] = '{fs: 3'd1, st: 3'd1, relu: 1'b1, kind: 2, n: 4,  exp_cnt: 4,  exp_first: 16'h0000};
        tbl[4] = '{fs: 3'd0, st: 3'd3, relu: 1'b0, kind: 1, n: 7,  exp_cnt: 3,  exp_first: 16'h0000};
        tbl[5] = '{fs: 3'd7, st: 3'd1, relu: 1'b0, kind: 1, n: 6,  exp_cnt: 2,  exp_first: 16'h0004};
        tbl[6] = '{fs: 3'd2, st: 3'd7, relu: 1'b0, kind: 1, n: 16, exp_cnt: 3,  exp_first: 16'h0001};

        reset        = 1'b1;
        filter_size  = 3'd0;
        stride       = 3'd0;
        relu_en      = 1'b0;
        row_start    = 1'b0;
        pe_out_valid = 1'b0;
        PE_Array_out = '0;
        out_ready    = 1'b1;
        model_clear();
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_row_out_count", 32'(row_out_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Valid samples before the first row_start are ignored.
        pe_out_valid = 1'b1;
        PE_Array_out = 16'h1234;
        repeat (3) step();
        idle(1);

        for (int i = 0; i < 7; i++) begin
            filter_size  = tbl[i].fs;
            stride       = tbl[i].st;
            relu_en      = tbl[i].relu;
            out_ready    = 1'b1;
            row_start    = 1'b1;
            pe_out_valid = 1'b1;
            PE_Array_out = sample_val(tbl[i].kind, 0);
            got.delete();
            step();
            row_start   = 1'b0;
            filter_size = 3'($urandom);
            stride      = 3'($urandom);
            relu_en     = 1'($urandom);
            for (int k = 1; k < tbl[i].n; k++) begin
                PE_Array_out = sample_val(tbl[i].kind, k);
                step();
            end
            idle(4);
            check("tbl_row_out_count", 32'(row_out_count), 32'(tbl[i].exp_cnt));
            check("tbl_num_outputs", 32'(got.size()), 32'(tbl[i].exp_cnt));
            if (got.size() > 0) begin
                check("tbl_first_output", 32'(got[0]), 32'(tbl[i].exp_first));
            end
            if (tbl[i].kind == 2 && got.size() == 4) begin
                check("relu_out1", 32'(got[1]), 32'h4000);
                check("relu_out2", 32'(got[2]), 32'h0000);
                check("relu_out3", 32'(got[3]), 32'h3C00);
            end
        end

        for (int c = 0; c < 400; c++) begin
            row_start    = (c == 0) || ($urandom_range(0, 19) == 0);
            filter_size  = 3'($urandom);
            stride       = 3'($urandom);
            relu_en      = 1'($urandom);
            pe_out_valid = ($urandom_range(0, 9) < 7);
            out_ready    = ($urandom_range(0, 9) < 6);
            PE_Array_out = 16'($urandom);
            step();
        end

        reset = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Full FIFO with simultaneous push and pop keeps count at 8, no overflow.
        filter_size  = 3'd1;
        stride       = 3'd1;
        relu_en      = 1'b0;
        out_ready    = 1'b0;
        row_start    = 1'b1;
        pe_out_valid = 1'b1;
        PE_Array_out = 16'h0100;
        step();
        row_start = 1'b0;
        for (int k = 1; k < 8; k++) begin
            PE_Array_out = 16'h0100 + 16'(k);
            step();
        end
        idle(1);
        check("full_count", 32'(fifo_count), 8);
        pe_out_valid = 1'b1;
        PE_Array_out = 16'h0200;
        out_ready    = 1'b1;
        step();
        check("pushpop_count", 32'(fifo_count), 8);
        check("pushpop_overflow", 32'(overflow), 0);
        check("pushpop_head", 32'(out_data), 32'h0101);
        idle(10);

        // Overflow: 10 samples into a stalled 8-deep FIFO.
        out_ready    = 1'b0;
        row_start    = 1'b1;
        pe_out_valid = 1'b1;
        PE_Array_out = 16'h0300;
        step();
        row_start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            PE_Array_out = 16'h0300 + 16'(k);
            step();
        end
        idle(1);
        check("ovf_count", 32'(fifo_count), 8);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_head", 32'(out_data), 32'h0300);
        out_ready = 1'b1;
        got.delete();
        idle(10);
        check("ovf_drain_num", 32'(got.size()), 8);
        for (int j = 0; j < got.size() && j < 8; j++) begin
            check("ovf_drain_order", 32'(got[j]), 32'h0300 + 32'(j));
        end
        check("ovf_sticky", 32'(overflow), 1);

        // Gapped valids during warm-up, then a mid-row restart that keeps FIFO contents.
        out_ready    = 1'b0;
        filter_size  = 3'd4;
        stride       = 3'd1;
        row_start    = 1'b1;
        pe_out_valid = 1'b0;
        step();
        row_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            pe_out_valid = (k % 2 == 1);
            PE_Array_out = 16'h0400 + 16'(k);
            step();
        end
        check("gap_row_count", 32'(row_out_count), 2);
        check("gap_fifo_count", 32'(fifo_count), 2);
        row_start    = 1'b1;
        pe_out_valid = 1'b0;
        step();
        row_start = 1'b0;
        check("restart_row_count", 32'(row_out_count), 0);
        check("restart_fifo_kept", 32'(fifo_count), 2);
        pe_out_valid = 1'b1;
        PE_Array_out = 16'h0500;
        repeat (3) step();
        check("restart_warmup_count", 32'(row_out_count), 0);
        step();
        check("restart_first_keep", 32'(row_out_count), 1);
        check("restart_fifo_after", 32'(fifo_count), 3);
        pe_out_valid = 1'b0;

        // Asynchronous reset between edges with 3 entries buffered.
        #2;
        reset = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_fifo_count", 32'(fifo_count), 0);
        check("arst_row_out_count", 32'(row_out_count), 0);
        check("arst_overflow", 32'(overflow), 0);
        model_clear();
        @(posedge clk);
        #1;
        reset        = 1'b0;
        out_ready    = 1'b1;
        pe_out_valid = 1'b1;
        PE_Array_out = 16'h0600;
        repeat (5) step();
        check("post_rst_ignored_count", 32'(fifo_count), 0);
        check("post_rst_ignored_row", 32'(row_out_count), 0);
        filter_size  = 3'd1;
        row_start    = 1'b1;
        PE_Array_out = 16'h0700;
        step();
        row_start    = 1'b0;
        pe_out_valid = 1'b0;
        check("post_rst_keep", 32'(out_data), 32'h0700);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pe_array_out_collector.md
Name: pe_array_out_collector

Overview:
- Downstream stage of the 1D FP16 PE array. Consumes the per-cycle PE_Array_out stream and discards warm-up samples (the first filter_size-1 of each row).
- Decimates the remaining samples by stride, optionally applies FP16 ReLU, and buffers the kept results in a first-word-fall-through FIFO with a valid/ready output.
- Feeds the result write-back path.

Parameters:
- DATA_WIDTH, 16, FP16 sample width.
- FIFO_DEPTH, 8, number of output buffer entries; must be a power of 2 and at least 2.
- CNT_WIDTH, 8, width of row_out_count (saturating).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- filter_size  in  3  kernel taps, legal 1..5; 0 is treated as 1, and 6..7 are treated as 5.
- stride  in  3  decimation factor, legal 1..7; 0 is treated as 1.
- relu_en  in  1  clamp negative results to +0.
- row_start  in  1  one-cycle pulse; starts a new output row and latches the config.
- pe_out_valid  in  1  PE_Array_out holds a meaningful sample this cycle.
- PE_Array_out  in  DATA_WIDTH  sample from the PE array.
- out_data  out  DATA_WIDTH  FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- row_out_count  out  CNT_WIDTH  samples kept in the current row; saturates at all-ones.
- overflow  out  1  sticky: a kept sample was dropped because the FIFO was full.

Behaviour:
- Reset values: out_valid=0, out_data=0, fifo_count=0, row_out_count=0, overflow=0. All internal counters are 0. Latched config is fs=1, st=1, relu=0.
- Config latch:
  - On row_start, filter_size, stride and relu_en are clamped and latched.
  - A sample arriving in the same cycle as row_start uses the new (port) values and is sample index 0 of the new row.
  - Config changes without row_start are ignored.
- Row state machine:
  - States: IDLE, WARMUP, RUN.
  - IDLE goes to WARMUP on row_start.
  - WARMUP skip counter starts at fs-1. It goes to RUN immediately if fs=1.
  - In WARMUP, each pe_out_valid discards the sample and decrements the skip counter. When the counter reaches 0 the block moves to RUN, and the next valid sample is the first kept candidate.
  - RUN: a phase counter starts at 0. Each valid sample increments it mod st, and the sample is kept only when phase==0. Kept samples are samples fs-1, fs-1+st, fs-1+2st, … of the row.
  - row_start in any state restarts WARMUP: counters reload and row_out_count is cleared.
  - pe_out_valid in IDLE is ignored.
  - pe_out_valid=0 cycles do not advance any counter.
- ReLU: when latched relu=1 and sample bit[DATA_WIDTH-1]=1, the pushed value is 16'h0000. This covers -0 and sign-set NaN. Otherwise the sample passes bit-exact.
- FIFO:
  - First-word-fall-through. Latency is 1 cycle from a kept pe_out_valid sample to out_valid/out_data.
  - Pop occurs when out_valid && out_ready.
  - Push is accepted when not full, or when full with a pop in the same cycle; fifo_count is then unchanged.
  - Push to a full FIFO without a pop drops the sample, sets overflow (cleared only by reset) and leaves contents unchanged.
  - Simultaneous push and pop on an empty FIFO is impossible because out_valid=0 when empty.
  - Pointers wrap modulo FIFO_DEPTH.
  - row_out_count increments on every kept sample, including dropped ones, and saturates.
  - row_start does not flush the FIFO.
- Reset asserted mid-row: all state returns to the reset values, FIFO contents are lost, and the block sits in IDLE until the next row_start.

Decomposition:
- Package pe_array_pkg holds:
  - DATA_WIDTH=16, FP16_SIGN_BIT=15, FP16_ZERO=16'h0000;
  - MAX_FILTER=5, MAX_STRIDE=7;
  - an enum for the row states IDLE/WARMUP/RUN.
- Sub-module sync_fifo_fwft (DATA_WIDTH, FIFO_DEPTH): push/pop/full/empty/count. Overflow is detected in the parent.
- The warm-up/decimation FSM and ReLU live in the top module.

Test Plan:
- Basic warm-up and pass-through:
  - Stimulus: fs=5, st=1, relu=0, row_start, then 14 valid samples 0xC000,0xC400,… (-2,-4,…), out_ready=1.
  - Required: samples 0..3 discarded; 10 outputs in order starting with sample 4; row_out_count=10; overflow=0.
- Stride decimation:
  - Stimulus: fs=3, st=2, 12 samples carrying indices 0..11 as data.
  - Required: outputs are indices 2,4,6,8,10; row_out_count=5.
  - Repeat with st=0: must behave as st=1.
- ReLU:
  - Stimulus: relu=1, fs=1, st=1, samples 0xC000, 0x4000, 0x8000, 0x3C00.
  - Required: outputs 0x0000, 0x4000, 0x0000, 0x3C00.
- Backpressure and overflow:
  - Stimulus: FIFO_DEPTH=8, out_ready=0, fs=1, 10 samples.
  - Required: fifo_count=8, overflow=1, head = first sample.
  - Then out_ready=1: exactly 8 outputs in order and overflow stays 1.
  - Also check a full FIFO with push and pop in the same cycle: count stays 8 and no overflow.
- Gaps and mid-row restart:
  - Stimulus: fs=4 with pe_out_valid toggling 1/0.
  - Required: warm-up counts only valid cycles.
  - row_start issued after 2 kept samples: counters restart and the FIFO retains the 2 kept samples.
- Async reset mid-stream:
  - Stimulus: assert reset between clock edges while the FIFO holds 3 entries.
  - Required: out_valid, fifo_count, row_out_count and overflow go to 0 immediately.
  - After reset release, valid samples are ignored until row_start.
